// File: rtl/div_unit_seq.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, start/busy/valid handshake, flush abort.
module div_unit_seq #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [1:0]      i_div_op,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [1:0]       op_q;
  logic             rem_neg_q;
  logic             quo_neg_q;
  logic [XLEN-1:0]  dvs_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [CNT_W-1:0] cnt_q;

  // The most negative value maps to 2^(XLEN-1), which still fits unsigned.
  function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                input logic use_sign);
    logic signed [XLEN-1:0] neg_v;
    neg_v = -v;
    return (use_sign && v[XLEN-1]) ? $unsigned(neg_v) : $unsigned(v);
  endfunction

  function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v,
                                                input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic            in_signed;
  logic            in_div_zero;
  logic            in_overflow;
  logic            in_special;
  logic [XLEN-1:0] special_res;
  logic            start_ok;

  always_comb begin
    in_signed   = ~i_div_op[0];
    in_div_zero = (i_op_b == '0);
    in_overflow = in_signed && (i_op_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_op_b == '1);
    in_special  = in_div_zero || in_overflow;
    if (in_div_zero)
      special_res = i_div_op[1] ? i_op_a : '1;
    else
      special_res = i_div_op[1] ? '0 : i_op_a;
    start_ok = (state == IDLE) && i_start && !i_flush;
  end

  // Restoring step: shift {rem,quo}, subtract divisor when it does not borrow.
  logic [XLEN:0]   rem_sh;
  logic            no_borrow;
  logic [XLEN-1:0] rem_step;
  logic            op_signed;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] fix_res;

  always_comb begin
    rem_sh    = {rem_q, quo_q[XLEN-1]};
    no_borrow = (rem_sh >= {1'b0, dvs_q});
    rem_step  = no_borrow ? XLEN'(rem_sh - {1'b0, dvs_q}) : rem_sh[XLEN-1:0];
    op_signed = ~op_q[0];
    quo_fix   = negate_if(quo_q, op_signed && quo_neg_q);
    rem_fix   = negate_if(rem_q, op_signed && rem_neg_q);
    fix_res   = op_q[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = in_special ? DONE : CALC;
      CALC: if (cnt_q == CNT_W'(XLEN - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_flush && (state != IDLE)) state_nxt = IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q      <= '0;
      rem_neg_q <= 1'b0;
      quo_neg_q <= 1'b0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      o_result  <= '0;
    end else if (start_ok) begin
      op_q      <= i_div_op;
      rem_neg_q <= in_signed && i_op_a[XLEN-1];
      quo_neg_q <= in_signed && (i_op_a[XLEN-1] ^ i_op_b[XLEN-1]);
      dvs_q     <= magnitude(i_op_b, in_signed);
      quo_q     <= magnitude(i_op_a, in_signed);
      rem_q     <= '0;
      cnt_q     <= '0;
      if (in_special) o_result <= special_res;
    end else if (!i_flush) begin
      if (state == CALC) begin
        rem_q <= rem_step;
        quo_q <= {quo_q[XLEN-2:0], no_borrow};
        cnt_q <= cnt_q + 1'b1;
      end else if (state == FIX) begin
        o_result <= fix_res;
      end
    end
  end

  assign o_busy  = (state != IDLE);
  assign o_valid = (state == DONE);

endmodule

// File: tb/tb_div_unit_seq.sv
// Scoreboard bench for div_unit_seq: directed RV32M cases plus randomized ops
// against an arithmetic reference model.
module tb_div_unit_seq;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            flush;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;

  int n_vec = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_res = '0;

  always #5 clk = ~clk;

  div_unit_seq #(.XLEN(XLEN)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_flush(flush),
    .i_div_op(op), .i_op_a(a), .i_op_b(b),
    .o_busy(busy), .o_valid(valid), .o_result(result)
  );

  function automatic logic is_special(input logic [1:0] f_op, input logic [31:0] fa,
                                      input logic [31:0] fb);
    return (fb == 0) || (!f_op[0] && fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF);
  endfunction

  // RISC-V division semantics using native truncating integer division.
  function automatic logic [31:0] ref_div(input logic [1:0] f_op, input logic [31:0] fa,
                                          input logic [31:0] fb);
    int sa;
    int sb;
    sa = fa;
    sb = fb;
    if (fb == 0) return f_op[1] ? fa : 32'hFFFF_FFFF;
    if (!f_op[0] && fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF)
      return f_op[1] ? 32'h0 : fa;
    case (f_op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return fa / fb;
      2'b10:   return 32'(sa % sb);
      default: return fa % fb;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every o_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got result %h, expected no valid (t=%0t)", result, $time);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  // Waits for o_valid; returns the negedge index after the accepting edge (0 on timeout).
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge with the unit idle.
  task automatic run_op(input string name, input logic [1:0] t_op, input logic [31:0] ta,
                        input logic [31:0] tb);
    int lat;
    int exp_lat;
    logic [31:0] r;
    r = ref_div(t_op, ta, tb);
    exp_lat = is_special(t_op, ta, tb) ? 1 : XLEN + 2;
    op = t_op; a = ta; b = tb; start = 1'b1;
    exp_q.push_back(r);
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    wait_valid(lat);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    last_res = r;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat;
    logic seen;
    logic [1:0] r_op;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #2;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_valid", {31'b0, valid}, 32'd0);
    check("reset_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7);
    run_op("div_m7_2",   2'b00, -32'sd7, 32'd2);
    run_op("rem_m7_2",   2'b10, -32'sd7, 32'd2);
    run_op("rem_7_m2",   2'b10, 32'd7, -32'sd2);
    run_op("div_5_0",    2'b00, 32'd5, 32'd0);
    run_op("remu_5_0",   2'b11, 32'd5, 32'd0);
    run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_big",   2'b01, 32'hFFFF_FFFF, 32'h8000_0001);

    // Start while busy is ignored.
    op = 2'b01; a = 32'd1000; b = 32'd3; start = 1'b1;
    exp_q.push_back(32'd333);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    op = 2'b01; a = 32'd50; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(lat);
    check("busy_start_latency", 32'(lat + 10), 32'(XLEN + 2));
    last_res = 32'd333;
    @(negedge clk);
    check("after_ignored_busy", {31'b0, busy}, 32'd0);

    // Flush mid-operation: no valid, result held.
    op = 2'b00; a = 32'd12345; b = 32'd17; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid === 1'b1) seen = 1'b1;
    end
    check("flush_no_valid", {31'b0, seen}, 32'd0);
    check("flush_result_held", result, last_res);

    // Flush wins over start in IDLE.
    op = 2'b01; a = 32'd9; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_prio_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset mid-CALC.
    op = 2'b01; a = 32'd777; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_valid", {31'b0, valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("b2b_first",  2'b01, 32'd1_000_000, 32'd999);
    run_op("b2b_second", 2'b01, 32'hDEAD_BEEF, 32'd16);

    // Randomized ops with biased corner operands.
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom);
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 255); rb = $urandom_range(1, 15); end
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      run_op("random", r_op, ra, rb);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
